// File: rtl/const_seq.sv
// rtl/const_seq.sv - emits DEPTH constants BASE+i*STEP+OFFSET over a valid/ready stream
// Optional running-sum output enabled by defining CONST_SEQ_SUM_EN.
module const_seq #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int BASE   = 10,
  parameter int STEP   = 10,
  parameter int OFFSET = 7,
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             start,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [IW-1:0]    out_index,
  output logic             busy,
  output logic             done
`ifdef CONST_SEQ_SUM_EN
  , output logic [WIDTH+7:0] sum_out
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  state_t          state, state_n;
  logic [IW-1:0]   idx, idx_n;
  int              value;
  logic            xfer;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      IDLE: if (start) begin
        state_n = RUN;
        idx_n   = '0;
      end
      RUN: if (out_ready) begin
        if (idx == LAST) begin
          state_n = DONE;
          idx_n   = '0;
        end else begin
          idx_n = idx + IW'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Evaluate at full int precision, then keep the low WIDTH bits.
  always_comb begin
    value = BASE + int'(idx) * STEP + OFFSET;
  end

  assign out_valid = (state == RUN);
  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign out_index = idx;
  assign out_data  = (state == RUN) ? WIDTH'(value) : '0;
  assign xfer      = out_valid && out_ready;

`ifdef CONST_SEQ_SUM_EN
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sum_out <= '0;
    end else if (state == IDLE && start) begin
      sum_out <= '0;
    end else if (xfer) begin
      sum_out <= sum_out + (WIDTH + 8)'(out_data);
    end
  end
`endif

endmodule

// File: tb/tb_const_seq.sv
// tb/tb_const_seq.sv - directed self-checking bench for const_seq
module tb_const_seq;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       out_ready = 1'b1;

  logic       d_valid, d_busy, d_done;
  logic [7:0] d_data;
  logic [1:0] d_index;
  logic       w_valid, w_busy, w_done;
  logic [7:0] w_data;
  logic [1:0] w_index;
  logic       s_valid, s_busy, s_done;
  logic [7:0] s_data;
  logic [0:0] s_index;
`ifdef CONST_SEQ_SUM_EN
  logic [15:0] d_sum, w_sum, s_sum;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  const_seq u_dut (
    .clock(clock), .rst_n(rst_n), .start(start), .out_ready(out_ready),
    .out_valid(d_valid), .out_data(d_data), .out_index(d_index),
    .busy(d_busy), .done(d_done)
`ifdef CONST_SEQ_SUM_EN
    , .sum_out(d_sum)
`endif
  );

  const_seq #(.WIDTH(8), .DEPTH(4), .BASE(250), .STEP(1), .OFFSET(7)) u_wrap (
    .clock(clock), .rst_n(rst_n), .start(start), .out_ready(out_ready),
    .out_valid(w_valid), .out_data(w_data), .out_index(w_index),
    .busy(w_busy), .done(w_done)
`ifdef CONST_SEQ_SUM_EN
    , .sum_out(w_sum)
`endif
  );

  const_seq #(.DEPTH(1)) u_single (
    .clock(clock), .rst_n(rst_n), .start(start), .out_ready(out_ready),
    .out_valid(s_valid), .out_data(s_data), .out_index(s_index),
    .busy(s_busy), .done(s_done)
`ifdef CONST_SEQ_SUM_EN
    , .sum_out(s_sum)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_d(input string tag, input logic v, input logic b, input logic dn,
                         input logic [7:0] data, input logic [1:0] index);
    check({tag, ".valid"}, 32'(d_valid), 32'(v));
    check({tag, ".busy"},  32'(d_busy),  32'(b));
    check({tag, ".done"},  32'(d_done),  32'(dn));
    check({tag, ".data"},  32'(d_data),  32'(data));
    check({tag, ".index"}, 32'(d_index), 32'(index));
  endtask

  logic [7:0] exp_d [4] = '{8'd17, 8'd27, 8'd37, 8'd47};
  logic [7:0] exp_w [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
  // Per-cycle pattern with start held: V=valid, D=done, I=idle
  string pat = "VVVVDIVVVVDI";

  initial begin
    #2;
    check_d("reset", 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
    check("reset.single_valid", 32'(s_valid), 32'd0);
    @(negedge clock);
    rst_n = 1'b1;
    tick();
    check_d("idle_after_reset", 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);

    // Full sequence with ready held high, all three instances in parallel
    start = 1'b1;
    tick();
    start = 1'b0;
    check("first.single_valid", 32'(s_valid), 32'd1);
    check("first.single_data",  32'(s_data),  32'd17);
    check("first.single_index", 32'(s_index), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check_d($sformatf("seq[%0d]", i), 1'b1, 1'b1, 1'b0, exp_d[i], 2'(i));
      check($sformatf("wrap[%0d].data", i),  32'(w_data),  32'(exp_w[i]));
      check($sformatf("wrap[%0d].index", i), 32'(w_index), i);
      if (i == 1) begin
        check("single.done", 32'(s_done), 32'd1);
        check("single.valid_in_done", 32'(s_valid), 32'd0);
      end
      if (i == 2) check("single.idle_done", 32'(s_done), 32'd0);
      tick();
    end
    check_d("seq.done", 1'b0, 1'b0, 1'b1, 8'd0, 2'd0);
    check("wrap.done", 32'(w_done), 32'd1);
`ifdef CONST_SEQ_SUM_EN
    check("sum.total", 32'(d_sum), 32'd128);
`endif
    tick();
    check_d("seq.idle", 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);

    // Stall at index 2 for three cycles
    start = 1'b1;
    tick();
    start = 1'b0;
`ifdef CONST_SEQ_SUM_EN
    check("sum.cleared", 32'(d_sum), 32'd0);
`endif
    tick();
`ifdef CONST_SEQ_SUM_EN
    check("sum.first", 32'(d_sum), 32'd17);
`endif
    tick();
    check_d("stall.enter", 1'b1, 1'b1, 1'b0, 8'd37, 2'd2);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_d($sformatf("stall[%0d]", i), 1'b1, 1'b1, 1'b0, 8'd37, 2'd2);
    end
    out_ready = 1'b1;
    tick();
    check_d("stall.release", 1'b1, 1'b1, 1'b0, 8'd47, 2'd3);
    tick();
    check_d("stall.done", 1'b0, 1'b0, 1'b1, 8'd0, 2'd0);
    tick();

    // Asynchronous reset mid-cycle at index 1
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check_d("prereset", 1'b1, 1'b1, 1'b0, 8'd27, 2'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_d("async_reset", 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
    #1;
    rst_n = 1'b1;
    tick();
    check_d("post_reset_idle", 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_d("restart", 1'b1, 1'b1, 1'b0, 8'd17, 2'd0);
    for (int i = 0; i < 5; i++) tick();
    check_d("restart.idle", 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);

    // Start held high: 4 valid, 1 done, 1 idle, repeating
    start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 11) start = 1'b0;
      check($sformatf("hold[%0d].valid", i), 32'(d_valid), 32'(pat[i] == "V"));
      check($sformatf("hold[%0d].done", i),  32'(d_done),  32'(pat[i] == "D"));
      if (pat[i] == "V")
        check($sformatf("hold[%0d].data", i), 32'(d_data), 32'(exp_d[i % 6]));
    end
    tick();
    check_d("hold.end", 1'b0, 1'b0, 1'b0, 8'd0, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/const_seq.md
CONST_SEQ -- requirements
Module: const_seq

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, bit width of each emitted constant.
REQ-002 SHALL provide parameter DEPTH, default 4, number of constants per sequence (legal range 1..256).
REQ-003 SHALL provide parameter BASE, default 10, base term of the constant expression.
REQ-004 SHALL provide parameter STEP, default 10, per-index increment of the constant expression.
REQ-005 SHALL provide parameter OFFSET, default 7, fixed term added to every constant.
REQ-006 SHALL provide port clock  input  1  sole clock, all state on rising edge.
REQ-007 SHALL provide port rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL provide port start  input  1  request to emit one sequence.
REQ-009 SHALL provide port out_ready  input  1  consumer accepts out_data this cycle.
REQ-010 SHALL provide port out_valid  output  1  out_data/out_index hold a valid element.
REQ-011 SHALL provide port out_data  output  WIDTH  current constant.
REQ-012 SHALL provide port out_index  output  max(1,$clog2(DEPTH))  index of current constant.
REQ-013 SHALL provide port busy  output  1  high in RUN state.
REQ-014 SHALL provide port done  output  1  one-cycle pulse after last element transfers.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-016 IDLE: out_valid=0, busy=0, done=0; start=1 at a rising edge SHALL enter RUN with index 0.
REQ-017 RUN: out_valid=1, busy=1, out_data = (BASE + index*STEP + OFFSET) mod 2^WIDTH, computed at full integer precision then truncated.
REQ-018 A transfer SHALL occur on a rising edge where out_valid=1 and out_ready=1.
REQ-019 While out_valid=1 and out_ready=0, out_data and out_index SHALL remain stable (no stall-cycle change).
REQ-020 Transfer at index < DEPTH-1 SHALL increment index by 1 and stay in RUN; no bubble cycles between transfers.
REQ-021 Transfer at index = DEPTH-1 SHALL enter DONE; index SHALL wrap to 0.
REQ-022 DONE: done=1, out_valid=0, busy=0 for exactly one cycle, then IDLE unconditionally.
REQ-023 start SHALL be ignored in RUN and DONE; start held high in IDLE begins a new sequence the cycle after DONE exits.
REQ-024 DEPTH=1 SHALL emit a single element then DONE.
REQ-025 First out_valid SHALL assert exactly one cycle after the start edge (latency 1).

Reset
REQ-026 rst_n=0 SHALL immediately (asynchronously) force IDLE, index 0, and all outputs to 0, including mid-sequence and during DONE.
REQ-027 After rst_n deasserts, the block SHALL act on start no earlier than the first rising edge with rst_n=1.

Configuration
REQ-028 Macro CONST_SEQ_SUM_EN defined SHALL add output port sum_out (WIDTH+8 bits): running sum of transferred out_data values, cleared on reset and on entry to RUN, held through DONE/IDLE.
REQ-029 Macro CONST_SEQ_SUM_EN undefined SHALL omit sum_out and its accumulator; all other behaviour identical.

Verification
REQ-030 Defaults, start pulse, out_ready=1 -> out_data 17,27,37,47 on consecutive cycles, index 0..3, then done=1 one cycle, then IDLE.
REQ-031 Defaults, out_ready low for 3 cycles at index 2 -> out_data stays 37, out_index stays 2 for 4 cycles, then 47.
REQ-032 WIDTH=8, BASE=250, STEP=1, OFFSET=7 -> out_data 1,2,3,4 (wrap mod 256).
REQ-033 rst_n=0 asynchronously mid-cycle at index 1 -> out_valid, busy, done, out_data go 0 immediately; next start restarts at 17.
REQ-034 start held high continuously, defaults -> sequences repeat with pattern 4 valid cycles, 1 done cycle, 1 idle cycle; start during RUN has no effect.
REQ-035 CONST_SEQ_SUM_EN defined, defaults, full sequence -> sum_out=128 after done, reset to 0 then 17 on next sequence's first transfer.
